// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// byte width and the bytes-per-word helper.
package prog_loader_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  // ceil((isize + 1) / BYTE_W)
  function automatic int unsigned bpw(input int unsigned isize);
    return (isize + BYTE_W) / BYTE_W;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-RAM write port of the loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int unsigned Psize = 6,
  parameter int unsigned Isize = 24
);

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [Psize-1:0]  wr_addr;
  logic [Isize:0]    wr_data;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/prog_word_asm.sv
// Big-endian word assembler: shifts accepted bytes in and pulses word_rdy the
// cycle after the last byte of a word has been taken.
module prog_word_asm
  import prog_loader_pkg::*;
#(
  parameter int unsigned Isize = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              last_byte,
  output logic              word_rdy,
  output logic [Isize:0]    word
);

  localparam int unsigned BPW = bpw(Isize);
  localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [Isize:0] sh;
  logic [CW-1:0]  cnt;

  assign last_byte = (cnt == CW'(BPW - 1));
  assign word      = sh;

  // The register is only Isize+1 wide, so bits above Isize fall off the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh       <= '0;
      cnt      <= '0;
      word_rdy <= 1'b0;
    end else begin
      word_rdy <= take && last_byte;
      if (take) begin
        sh  <= {sh[Isize-BYTE_W:0], byte_in};
        cnt <= last_byte ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into program RAM and
// releases the core from hold once a load completes with a good checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned Psize = 6,
  parameter int unsigned Isize = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  prog_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);

  state_t            state, state_nx;
  logic [Psize-1:0]  nlast;
  logic [Psize-1:0]  widx;
  logic [BYTE_W-1:0] csum;
  logic              take;
  logic              start_acc;
  logic              last_byte;
  logic              word_rdy;
  logic [Isize:0]    word;

  assign take      = bus.rx_valid && bus.rx_ready;
  assign start_acc = start && (state inside {IDLE, DONE, ERR});

  prog_word_asm #(.Isize(Isize)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .take      (take && (state == DATA)),
    .byte_in   (bus.rx_data),
    .last_byte (last_byte),
    .word_rdy  (word_rdy),
    .word      (word)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // widx advances after each write but parks at N-1 so the last address holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      nlast <= '0;
      widx  <= '0;
      csum  <= '0;
    end else if (start_acc) begin
      widx <= '0;
      csum <= '0;
    end else begin
      if (take && (state inside {LEN, DATA})) csum <= csum ^ bus.rx_data;
      if (take && (state == LEN))             nlast <= bus.rx_data[Psize-1:0];
      if (word_rdy && (widx != nlast))        widx <= widx + Psize'(1);
    end
  end

  always_comb begin
    state_nx     = state;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    cpu_hold     = 1'b1;
    bus.rx_ready = 1'b0;
    bus.wr_en    = word_rdy;
    bus.wr_addr  = widx;
    bus.wr_data  = word;
    case (state)
      IDLE: if (start) state_nx = LEN;
      LEN: begin
        busy         = 1'b1;
        bus.rx_ready = 1'b1;
        if (take) state_nx = DATA;
      end
      DATA: begin
        busy         = 1'b1;
        bus.rx_ready = 1'b1;
        if (take && last_byte && (widx == nlast)) state_nx = CSUM;
      end
      CSUM: begin
        busy         = 1'b1;
        bus.rx_ready = 1'b1;
        if (take) state_nx = (csum == bus.rx_data) ? DONE : ERR;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nx = LEN;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_nx = LEN;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: program writes are checked against a
// scoreboard filled as word bytes are driven; status outputs checked inline.
module tb_prog_loader;

  localparam int unsigned PS = 6;
  localparam int unsigned IS = 24;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold, busy, done, error;

  int vectors     = 0;
  int miscompares = 0;

  logic [PS+IS:0] sb[$];
  logic [31:0]    words[64];

  prog_loader_if #(.Psize(PS), .Isize(IS)) bus ();

  prog_loader #(.Psize(PS), .Isize(IS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin
    logic [PS+IS:0] e;
    if (bus.wr_en !== 1'b0) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL wr_unexpected observed wr_en=%b addr=%h data=%h expected no write",
               bus.wr_en, bus.wr_addr, bus.wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e[PS+IS:IS+1]));
        chk("wr_data", 32'(bus.wr_data), 32'(e[IS:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [7:0] b, input bit gaps, input bit st);
    int t = 0;
    while (bus.rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      vectors++;
      miscompares++;
      $error("FAIL rx_ready_timeout observed=0 expected=1");
    end
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    start        = st;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    start        = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends length, nw words from words[] and the checksum (inverted if bad).
  task automatic load(input logic [7:0] lenb, input int nw, input bit bad,
                      input bit gaps, input int start_at);
    logic [7:0] cs;
    logic [7:0] b;
    cs = lenb;
    send(lenb, gaps, 1'b0);
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++) begin
        b  = words[w][31-8*k -: 8];
        cs = cs ^ b;
        if (k == 3) sb.push_back({PS'(w), words[w][IS:0]});
        send(b, gaps, (w * 4 + k) == start_at);
      end
    end
    send(bad ? ~cs : cs, gaps, 1'b0);
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e, input logic h);
    chk({tag, "_done"},  32'(done),     32'(d));
    chk({tag, "_error"}, 32'(error),    32'(e));
    chk({tag, "_hold"},  32'(cpu_hold), 32'(h));
    chk({tag, "_busy"},  32'(busy),     32'(0));
    chk({tag, "_sb"},    32'(sb.size()), 32'(0));
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.rx_ready), 32'(0));
    chk("rst_wr_en", 32'(bus.wr_en),    32'(0));
    chk("rst_addr",  32'(bus.wr_addr),  32'(0));
    chk("rst_data",  32'(bus.wr_data),  32'(0));
    chk("rst_hold",  32'(cpu_hold),     32'(1));
    chk("rst_busy",  32'(busy),         32'(0));
    chk("rst_done",  32'(done),         32'(0));
    chk("rst_error", 32'(error),        32'(0));
    reset = 1'b0;
    @(negedge clk);

    // single word, good checksum
    words[0] = 32'h0123_4567;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'(1));
    chk("t1_ready", 32'(bus.rx_ready), 32'(1));
    load(8'h00, 1, 1'b0, 1'b0, -1);
    chk_status("t1", 1'b1, 1'b0, 1'b0);

    // top-byte truncation
    words[0] = 32'h0000_0001;
    words[1] = 32'h01FF_FFFF;
    words[2] = 32'hFFFF_FFFE;
    words[3] = 32'hFE00_0000;
    pulse_start();
    load(8'h03, 4, 1'b0, 1'b0, -1);
    chk_status("t2", 1'b1, 1'b0, 1'b0);

    // bad checksum: write still lands, core stays held
    words[0] = 32'h0123_4567;
    pulse_start();
    load(8'h00, 1, 1'b1, 1'b0, -1);
    chk_status("t3", 1'b0, 1'b1, 1'b1);

    // length byte upper bits ignored for N but included in checksum
    words[0] = 32'h00AB_CDEF;
    pulse_start();
    load(8'hC0, 1, 1'b0, 1'b0, -1);
    chk_status("t3b", 1'b1, 1'b0, 1'b0);

    // full capacity with random valid gaps
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    pulse_start();
    load(8'h3F, 64, 1'b0, 1'b1, -1);
    chk_status("t4", 1'b1, 1'b0, 1'b0);
    chk("t4_last_addr", 32'(bus.wr_addr), 32'h3F);

    // reset partway through word 1
    words[0] = 32'h0011_2233;
    pulse_start();
    send(8'h01, 1'b0, 1'b0);
    sb.push_back({PS'(0), words[0][IS:0]});
    send(8'h00, 1'b0, 1'b0);
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    send(8'h44, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_busy",  32'(busy),         32'(0));
    chk("t5_ready", 32'(bus.rx_ready), 32'(0));
    chk("t5_wr_en", 32'(bus.wr_en),    32'(0));
    chk("t5_hold",  32'(cpu_hold),     32'(1));
    chk("t5_addr",  32'(bus.wr_addr),  32'(0));
    reset = 1'b0;
    @(negedge clk);
    words[0] = 32'h0155_AA55;
    words[1] = 32'h00C3_3C00;
    pulse_start();
    load(8'h01, 2, 1'b0, 1'b0, -1);
    chk_status("t5", 1'b1, 1'b0, 1'b0);

    // start during DATA is ignored
    words[0] = 32'h0102_0304;
    words[1] = 32'h0506_0708;
    pulse_start();
    load(8'h01, 2, 1'b0, 1'b0, 5);
    chk_status("t6", 1'b1, 1'b0, 1'b0);

    // restart from DONE
    pulse_start();
    chk("t6b_done", 32'(done),     32'(0));
    chk("t6b_hold", 32'(cpu_hold), 32'(1));
    chk("t6b_busy", 32'(busy),     32'(1));
    words[0] = 32'h0076_5432;
    load(8'h00, 1, 1'b0, 1'b0, -1);
    chk_status("t6b", 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("end_sb", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
